// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle CPU control path: FSM states, opcode/funct
// values and datapath mux selects (the datapath muxes use the same constants).
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_INIT      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_R_WB      = 4'd8,
        S_EXEC_I    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13,
        S_JR        = 4'd14
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;

    localparam logic [1:0] SRCB_REG_B   = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_R31 = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG_A  = 2'b11;

    // DECODE dispatch target; S_FETCH marks an unsupported instruction.
    function automatic state_e dispatch(input logic [5:0] opcode, input logic [5:0] funct);
        state_e s;
        s = S_FETCH;
        case (opcode)
            OP_LW, OP_SW:     s = S_MEM_ADDR;
            OP_ADDI, OP_XORI: s = S_EXEC_I;
            OP_BEQ, OP_BNE:   s = S_BRANCH;
            OP_J:             s = S_JUMP;
            OP_JAL:           s = S_JAL;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_SLT, FN_XOR: s = S_EXEC_R;
                    FN_JR:                          s = S_JR;
                    default:                        s = S_FETCH;
                endcase
            end
            default:          s = S_FETCH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decode.sv
// ALU operation decode: R-type funct or I-type opcode to alu_op, purely combinational.
module multicycle_alu_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_op_o
);

    always_comb begin
        alu_op_o = ALU_ADD;
        if (opcode_i == OP_RTYPE) begin
            case (funct_i)
                FN_SUB:  alu_op_o = ALU_SUB;
                FN_SLT:  alu_op_o = ALU_SLT;
                FN_XOR:  alu_op_o = ALU_XOR;
                default: alu_op_o = ALU_ADD;
            endcase
        end else if (opcode_i == OP_XORI) begin
            alu_op_o = ALU_XOR;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle CPU main sequencer (Moore FSM) driving all datapath selects and enables.
// Define MEM_WAIT_EN to hold FETCH/MEM_READ/MEM_WRITE until mem_ready_i is high.
//
//   state       | meaning
//   S_INIT      | after reset, all outputs low
//   S_FETCH     | read instr into IR, PC <= PC+4
//   S_DECODE    | branch target into ALUOut, dispatch on opcode/funct
//   S_MEM_ADDR  | effective address for LW/SW
//   S_MEM_READ  | load data into MDR
//   S_MEM_WB    | MDR to rt
//   S_MEM_WRITE | store reg B
//   S_EXEC_R    | R-type ALU op
//   S_R_WB      | ALUOut to rd
//   S_EXEC_I    | ADDI/XORI ALU op
//   S_I_WB      | ALUOut to rt
//   S_BRANCH    | compare, conditional PC <= ALUOut
//   S_JUMP      | PC <= jump target
//   S_JAL       | r31 <= PC, PC <= jump target
//   S_JR        | PC <= reg A
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       ir_write_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       iord_o,
    output logic       alu_srca_o,
    output logic [1:0] alu_srcb_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] reg_dst_o,
    output logic [1:0] mem_to_reg_o,
    output logic [1:0] pc_src_o,
    output logic       illegal_op_o
);

    state_e     state_q, state_d;
    state_e     dispatch_st;
    logic [2:0] alu_op_dec;
    logic       mem_go;

`ifdef MEM_WAIT_EN
    assign mem_go = mem_ready_i;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready_i;
    assign mem_go           = 1'b1;
`endif

    assign dispatch_st = dispatch(opcode_i, funct_i);

    multicycle_alu_decode u_alu_decode (
        .opcode_i (opcode_i),
        .funct_i  (funct_i),
        .alu_op_o (alu_op_dec)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:      state_d = S_FETCH;
            S_FETCH:     if (mem_go) state_d = S_DECODE;
            S_DECODE:    state_d = dispatch_st;
            S_MEM_ADDR:  state_d = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_go) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_go) state_d = S_FETCH;
            S_EXEC_R:    state_d = S_R_WB;
            S_EXEC_I:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        iord_o       = 1'b0;
        alu_srca_o   = 1'b0;
        alu_srcb_o   = SRCB_REG_B;
        alu_op_o     = ALU_ADD;
        reg_dst_o    = REGDST_RT;
        mem_to_reg_o = M2R_ALUOUT;
        pc_src_o     = PCSRC_ALU;
        illegal_op_o = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_o = mem_go;
                pc_write_o = mem_go;
                alu_srcb_o = SRCB_FOUR;
            end
            S_DECODE: begin
                alu_srcb_o   = SRCB_IMM_SH2;
                illegal_op_o = (dispatch_st == S_FETCH);
            end
            S_MEM_ADDR: begin
                alu_srca_o = 1'b1;
                alu_srcb_o = SRCB_IMM;
            end
            S_MEM_READ:  iord_o = 1'b1;
            S_MEM_WB: begin
                mem_to_reg_o = M2R_MDR;
                reg_write_o  = 1'b1;
            end
            S_MEM_WRITE: begin
                iord_o      = 1'b1;
                mem_write_o = mem_go;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_srca_o = 1'b1;
                alu_srcb_o = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_REG_B;
                alu_op_o   = alu_op_dec;
            end
            S_R_WB: begin
                reg_dst_o   = REGDST_RD;
                reg_write_o = 1'b1;
            end
            S_I_WB:      reg_write_o = 1'b1;
            S_BRANCH: begin
                alu_srca_o = 1'b1;
                alu_op_o   = ALU_SUB;
                pc_src_o   = PCSRC_ALUOUT;
                pc_write_o = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
            end
            S_JUMP: begin
                pc_src_o   = PCSRC_JUMP;
                pc_write_o = 1'b1;
            end
            S_JAL: begin
                reg_dst_o    = REGDST_R31;
                mem_to_reg_o = M2R_PC;
                reg_write_o  = 1'b1;
                pc_src_o     = PCSRC_JUMP;
                pc_write_o   = 1'b1;
            end
            S_JR: begin
                pc_src_o   = PCSRC_REG_A;
                pc_write_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
